// File: rtl/cb_pkg.sv
// Shared common-block package.
// Holds the default counter width and the legal synchroniser depth range
// used by the line-filter blocks, plus the per-channel transition kind.
package cb_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned SYNC_DEF  = 2;
  localparam int unsigned SYNC_MIN  = 2;
  localparam int unsigned SYNC_MAX  = 4;
  localparam int unsigned CH_MAX    = 32;

  // Kind of transition a channel accepts on the current edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/cb_line_filter_ch.sv
// Single-channel line filter: input synchroniser, stability counter and
// registered output level with one-cycle rise/fall pulses.
//
// Ports:
//   clk_sys    - system clock, rising edge
//   rst        - synchronous active-high reset
//   rise_cnt   - stable cycles required to accept 0->1 (0 treated as 1)
//   fall_cnt   - stable cycles required to accept 1->0 (0 treated as 1)
//   en         - filter enable; when low the level holds and the count clears
//   raw        - asynchronous raw line input
//   level      - filtered, registered line level
//   rise_pulse - one-cycle pulse on the first cycle level shows 1
//   fall_pulse - one-cycle pulse on the first cycle level shows 0
//   chg_nxt    - combinational: a transition is accepted on the coming edge
module cb_line_filter_ch
  import cb_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_DEF,
  parameter logic        RST_BIT     = 1'b0
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [CNT_W-1:0] rise_cnt,
  input  logic [CNT_W-1:0] fall_cnt,
  input  logic             en,
  input  logic             raw,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             chg_nxt
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_sel;
  logic [CNT_W-1:0] limit;
  logic             s;
  edge_e            edge_kind;

  assign s = sync_q[SYNC_STAGES-1];

  // Threshold follows the current output level; a zero threshold behaves
  // like one so the limit (N-1) never underflows.
  always_comb begin
    n_sel     = level ? fall_cnt : rise_cnt;
    limit     = (n_sel == '0) ? '0 : n_sel - CNT_W'(1);
    edge_kind = EDGE_NONE;
    if (en && (s != level) && (cnt_q >= limit)) begin
      edge_kind = level ? EDGE_FALL : EDGE_RISE;
    end
  end

  assign chg_nxt = (edge_kind != EDGE_NONE);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q     <= {SYNC_STAGES{RST_BIT}};
      level      <= RST_BIT;
      cnt_q      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], raw};
      rise_pulse <= (edge_kind == EDGE_RISE);
      fall_pulse <= (edge_kind == EDGE_FALL);
      if (!en || (s == level)) begin
        cnt_q <= '0;
      end else if (cnt_q >= limit) begin
        // Comparing with >= lets a lowered threshold take effect at once.
        level <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cb_multi_line_filter.sv
// Multi-channel line filter: CH_NUM independent single-channel filters
// sharing rise/fall thresholds, plus a registered any-change flag.
//
// Ports:
//   clk_sys    - system clock, rising edge
//   rst        - synchronous active-high reset
//   rise_cnt   - stable cycles to accept a 0->1 transition (all channels)
//   fall_cnt   - stable cycles to accept a 1->0 transition (all channels)
//   ch_en      - per-channel filter enable
//   sig_in     - asynchronous raw line inputs
//   sig_out    - filtered, registered line levels
//   rise_pulse - per-channel one-cycle pulse on accepted 0->1
//   fall_pulse - per-channel one-cycle pulse on accepted 1->0
//   any_chg    - one-cycle OR of all rise/fall pulses
module cb_multi_line_filter
  import cb_pkg::*;
#(
  parameter int unsigned       CH_NUM      = 8,
  parameter int unsigned       CNT_W       = CNT_W_DEF,
  parameter int unsigned       SYNC_STAGES = SYNC_DEF,
  parameter logic [CH_NUM-1:0] RST_VAL     = '0
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [CNT_W-1:0]  rise_cnt,
  input  logic [CNT_W-1:0]  fall_cnt,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [CH_NUM-1:0] sig_in,
  output logic [CH_NUM-1:0] sig_out,
  output logic [CH_NUM-1:0] rise_pulse,
  output logic [CH_NUM-1:0] fall_pulse,
  output logic              any_chg
);

  if ((SYNC_STAGES < SYNC_MIN) || (SYNC_STAGES > SYNC_MAX)) begin : g_bad_sync
    $error("cb_multi_line_filter: SYNC_STAGES out of range");
  end
  if ((CH_NUM < 1) || (CH_NUM > CH_MAX)) begin : g_bad_ch
    $error("cb_multi_line_filter: CH_NUM out of range");
  end

  logic [CH_NUM-1:0] chg_nxt;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    cb_line_filter_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_BIT     (RST_VAL[i])
    ) u_ch (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .rise_cnt   (rise_cnt),
      .fall_cnt   (fall_cnt),
      .en         (ch_en[i]),
      .raw        (sig_in[i]),
      .level      (sig_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .chg_nxt    (chg_nxt[i])
    );
  end

  // Registered from the channels' next-edge accept flags so any_chg lines
  // up with the registered pulses rather than trailing them by a cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      any_chg <= 1'b0;
    end else begin
      any_chg <= |chg_nxt;
    end
  end

endmodule

// File: doc/cb_multi_line_filter.md
CB_MULTI_LINE_FILTER -- requirements
Module: cb_multi_line_filter

Interface
REQ-001 Parameter CH_NUM, default 8: number of independent line channels, range 1..32.
REQ-002 Parameter CNT_W, default 16: width of filter thresholds and per-channel counters.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..4.
REQ-004 Parameter RST_VAL, default {CH_NUM{1'b0}}: reset level of each filtered output.
REQ-005 clk_sys  in  1  single system clock; all logic is rising-edge clk_sys.
REQ-006 rst  in  1  reset, synchronous to clk_sys, active-high.
REQ-007 rise_cnt  in  CNT_W  stable cycles required to accept a 0->1 transition; shared by all channels.
REQ-008 fall_cnt  in  CNT_W  stable cycles required to accept a 1->0 transition; shared by all channels.
REQ-009 ch_en  in  CH_NUM  per-channel filter enable.
REQ-010 sig_in  in  CH_NUM  asynchronous raw line inputs.
REQ-011 sig_out  out  CH_NUM  filtered, registered line levels.
REQ-012 rise_pulse  out  CH_NUM  one-cycle pulse on an accepted 0->1 transition.
REQ-013 fall_pulse  out  CH_NUM  one-cycle pulse on an accepted 1->0 transition.
REQ-014 any_chg  out  1  one-cycle OR of all rise_pulse and fall_pulse bits.

Function
REQ-015 Each sig_in bit SHALL pass through SYNC_STAGES flip-flops marked ASYNC_REG; s[i] denotes the last stage.
REQ-016 Per channel, N SHALL be rise_cnt when sig_out[i]=0 and fall_cnt when sig_out[i]=1; N=0 SHALL be treated as 1.
REQ-017 When ch_en[i]=1 and s[i]!=sig_out[i] and cnt[i] < N-1, cnt[i] SHALL increment by 1.
REQ-018 When ch_en[i]=1 and s[i]!=sig_out[i] and cnt[i] >= N-1, sig_out[i] SHALL take s[i] at that edge and cnt[i] SHALL clear to 0.
REQ-019 When s[i]==sig_out[i], cnt[i] SHALL clear to 0; a glitch shorter than N cycles SHALL never change sig_out[i].
REQ-020 Latency from a clean sig_in edge to sig_out SHALL be exactly SYNC_STAGES+N clk_sys cycles.
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL be registered and assert for exactly the first cycle sig_out[i] shows its new level.
REQ-022 any_chg SHALL be registered and assert in the same cycle as any rise_pulse/fall_pulse bit.
REQ-023 When ch_en[i]=0, sig_out[i] SHALL hold, cnt[i] SHALL clear, and no pulses SHALL fire; synchronisers keep running.
REQ-024 On re-enable, filtering SHALL restart from cnt=0 against the held sig_out[i].
REQ-025 A change of rise_cnt/fall_cnt mid-count SHALL take effect immediately; if cnt[i] >= new N-1, the transition SHALL be accepted on the next qualifying edge.
REQ-026 cnt[i] SHALL never exceed N-1 and SHALL never wrap.
REQ-027 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted and pulsed in the same cycle.

Reset
REQ-028 While rst=1: synchronisers SHALL load RST_VAL, sig_out SHALL equal RST_VAL, counters SHALL be 0, and all pulses and any_chg SHALL be 0.
REQ-029 Reset asserted mid-count SHALL discard the count; no pulse SHALL be generated by reset release.

Structure
REQ-030 CNT_W default and SYNC_STAGES limits SHALL live in the shared common-block package cb_pkg.
REQ-031 One sub-module, cb_line_filter_ch (single-channel synchroniser, counter, and output), SHALL be instantiated CH_NUM times via generate; the top SHALL add only any_chg.

Verification
REQ-032 rise_cnt=4, sig_in[0] 0->1 held -> sig_out[0]=1 and rise_pulse[0]=1 exactly 6 cycles after the edge (SYNC_STAGES=2).
REQ-033 fall_cnt=10, sig_in[3] 1->0 for 9 cycles then back to 1 -> sig_out[3] stays 1 and no fall_pulse is generated.
REQ-034 rise_cnt=0 -> behaves as N=1; sig_out follows sig_in after 3 cycles.
REQ-035 ch_en[2]=0 during a 20-cycle sig_in[2] pulse with rise_cnt=5 -> no change; re-enable with sig_in[2]=1 -> sig_out[2]=1 5 cycles later.
REQ-036 All 8 inputs toggle together, rise_cnt=3 -> all sig_out bits change in one cycle, rise_pulse=8'hFF, and any_chg is a single 1-cycle pulse.
REQ-037 rst pulsed high mid-count with RST_VAL=8'h0F -> sig_out=8'h0F next cycle, counters 0, and no pulses fire.
